// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared constants and chunk adder for the pipelined adder
package adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;
    localparam int unsigned DEFAULT_CHUNK = 4;
    localparam int unsigned MAX_CHUNK     = 64;

    // Ripple add of the low n bits; the carry out of bit n-1 lands in bit MAX_CHUNK.
    function automatic logic [MAX_CHUNK:0] add_chunk(
        input logic [MAX_CHUNK-1:0] a,
        input logic [MAX_CHUNK-1:0] b,
        input logic                 cin,
        input int unsigned          n
    );
        logic [MAX_CHUNK:0] r;
        logic               c;
        r = '0;
        c = cin;
        for (int unsigned i = 0; i < MAX_CHUNK; i++) begin
            if (i < n) begin
                r[i] = a[i] ^ b[i] ^ c;
                c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
            end
        end
        r[MAX_CHUNK] = c;
        return r;
    endfunction

endpackage

// File: rtl/adder_pipe_stage.sv
// rtl/adder_pipe_stage.sv - one pipeline slice: resolves chunk IDX and registers its carry
module adder_pipe_stage
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CHUNK = DEFAULT_CHUNK,
    parameter int unsigned IDX   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_res_i,
    input  logic             in_carry_i,
    input  logic [WIDTH-1:0] in_a_i,
    input  logic [WIDTH-1:0] in_b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_res_o,
    output logic             out_carry_o,
    output logic [WIDTH-1:0] out_a_o,
    output logic [WIDTH-1:0] out_b_o,
    output logic             out_ovf_o
);

    localparam int unsigned LO = IDX * CHUNK;

    logic                 valid_q, valid_d;
    logic                 carry_q, carry_d;
    logic                 ovf_q, ovf_d;
    logic [WIDTH-1:0]     res_q, res_d;
    logic [WIDTH-1:0]     a_q, b_q;
    logic [MAX_CHUNK-1:0] a_ext, b_ext;
    logic [MAX_CHUNK:0]   sum;
    logic                 load;
    logic                 unused_sum;

    assign in_ready_o = !valid_q || out_ready_i;
    assign load       = in_valid_i && in_ready_o;
    assign unused_sum = ^sum;

    always_comb begin
        a_ext = '0;
        b_ext = '0;
        a_ext[CHUNK-1:0] = in_a_i[LO +: CHUNK];
        b_ext[CHUNK-1:0] = in_b_i[LO +: CHUNK];
        sum   = add_chunk(a_ext, b_ext, in_carry_i, CHUNK);
        res_d = in_res_i;
        res_d[LO +: CHUNK] = sum[CHUNK-1:0];
        carry_d = sum[MAX_CHUNK];
        // Only meaningful in the last slice, where res_d holds the full-width MSB.
        ovf_d   = (in_a_i[WIDTH-1] == in_b_i[WIDTH-1]) && (res_d[WIDTH-1] != in_a_i[WIDTH-1]);
        valid_d = in_ready_o ? in_valid_i : valid_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            res_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            valid_q <= valid_d;
            if (load) begin
                carry_q <= carry_d;
                ovf_q   <= ovf_d;
                res_q   <= res_d;
                a_q     <= in_a_i;
                b_q     <= in_b_i;
            end
        end
    end

    assign out_valid_o = valid_q;
    assign out_res_o   = res_q;
    assign out_carry_o = carry_q;
    assign out_a_o     = a_q;
    assign out_b_o     = b_q;
    assign out_ovf_o   = ovf_q;

endmodule

// File: rtl/adder_pipe.sv
// rtl/adder_pipe.sv - pipelined ripple-carry adder/subtractor, one CHUNK per stage
module adder_pipe
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CHUNK = DEFAULT_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned STAGES = WIDTH / CHUNK;

    if ((CHUNK < 1) || (CHUNK > MAX_CHUNK) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
        $error("adder_pipe: WIDTH must be a positive multiple of CHUNK (1..MAX_CHUNK)");
    end

    logic [STAGES:0]  v;
    logic [STAGES:0]  r;
    logic [STAGES:0]  c_s;
    logic [STAGES-1:0] ovf_s;
    logic [WIDTH-1:0] res_s [STAGES+1];
    logic [WIDTH-1:0] a_s   [STAGES+1];
    logic [WIDTH-1:0] b_s   [STAGES+1];
    logic             unused_tail;

    // Subtraction folds into addition: a + ~b + 1, with cin overridden.
    assign v[0]     = in_valid;
    assign res_s[0] = '0;
    assign a_s[0]   = a;
    assign b_s[0]   = sub ? ~b : b;
    assign c_s[0]   = sub | cin;
    assign r[STAGES] = out_ready;
    assign in_ready = rst_n & r[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        adder_pipe_stage #(
            .WIDTH (WIDTH),
            .CHUNK (CHUNK),
            .IDX   (k)
        ) u_stage (
            .clk         (clk),
            .rst_n       (rst_n),
            .in_valid_i  (v[k]),
            .in_ready_o  (r[k]),
            .in_res_i    (res_s[k]),
            .in_carry_i  (c_s[k]),
            .in_a_i      (a_s[k]),
            .in_b_i      (b_s[k]),
            .out_valid_o (v[k+1]),
            .out_ready_i (r[k+1]),
            .out_res_o   (res_s[k+1]),
            .out_carry_o (c_s[k+1]),
            .out_a_o     (a_s[k+1]),
            .out_b_o     (b_s[k+1]),
            .out_ovf_o   (ovf_s[k])
        );
    end

    assign out_valid   = v[STAGES];
    assign q           = res_s[STAGES];
    assign cout        = c_s[STAGES];
    assign ovf         = ovf_s[STAGES-1];
    assign unused_tail = ^{a_s[STAGES], b_s[STAGES], ovf_s};

endmodule
